bldc_commutation_sequencer: RTL and testbench

Closed-loop six-step commutation controller for the three-phase BLDC bridge. It synchronises and debounces the raw hall inputs H1..H3 and decodes them to a sector. It drives the high-side gates A/B/C with PWM chopping at a 4-bit duty, and the low-side gates AA/BB/CC steady-on. A dead-time gap is inserted on every pattern change; invalid hall codes and stalls are detected and shut the bridge down. It sits between the hall-sensor pins and the gate-driver outputs.

---
 rtl/bldc_pkg.sv | 66 ++++++
 rtl/bldc_commutation_sequencer_if.sv | 39 +++
 rtl/hall_debounce.sv | 63 ++++++
 rtl/bldc_commutation_sequencer.sv | 162 ++++++++++++++++
 tb/tb_bldc_commutation_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bldc_pkg.sv
// ============================================================================
//  Module      : bldc_pkg
//  Description : Shared types, tables and helpers for the BLDC commutation
//                sequencer (FSM encoding, hall decode, gate patterns).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bldc_pkg;

    localparam int PWM_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FLT  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] sector;
    } hall_dec_t;

    // Gate vector layout {A, B, C, AA, BB, CC}; entry 0 is the rightmost.
    localparam logic [5:0][5:0] GATE_TBL = {
        6'b001_010,     // 5: C / BB
        6'b001_100,     // 4: C / AA
        6'b010_100,     // 3: B / AA
        6'b010_001,     // 2: B / CC
        6'b100_001,     // 1: A / CC
        6'b100_010      // 0: A / BB
    };

    function automatic hall_dec_t hall_decode(input logic [2:0] code);
        hall_dec_t d;
        d.valid  = 1'b1;
        d.sector = 3'd0;
        case (code)
            3'b101:  d.sector = 3'd0;
            3'b100:  d.sector = 3'd1;
            3'b110:  d.sector = 3'd2;
            3'b010:  d.sector = 3'd3;
            3'b011:  d.sector = 3'd4;
            3'b001:  d.sector = 3'd5;
            default: d.valid  = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] eff_sector(input logic [2:0] s, input logic dir);
        if (!dir) begin
            return s;
        end
        return (s >= 3'd3) ? (s - 3'd3) : (s + 3'd3);
    endfunction

    function automatic logic [5:0] gate_drive(input logic [2:0] s, input logic hi_on);
        logic [5:0] g;
        g = (s < 3'd6) ? GATE_TBL[s] : 6'b000_000;
        return {g[5:3] & {3{hi_on}}, g[2:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bldc_commutation_sequencer_if.sv
// ============================================================================
//  Module      : bldc_commutation_sequencer_if
//  Description : Control, hall-sensor and gate-driver signal bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bldc_commutation_sequencer_if;
    import bldc_pkg::*;

    logic             EN;
    logic             DIR;
    logic [PWM_W-1:0] DUTY;
    logic             H1;
    logic             H2;
    logic             H3;
    logic             A;
    logic             B;
    logic             C;
    logic             AA;
    logic             BB;
    logic             CC;
    logic [2:0]       SECTOR;
    logic             FAULT;
    logic             STALL;

    modport master (
        output EN, DIR, DUTY, H1, H2, H3,
        input  A, B, C, AA, BB, CC, SECTOR, FAULT, STALL
    );

    modport slave (
        input  EN, DIR, DUTY, H1, H2, H3,
        output A, B, C, AA, BB, CC, SECTOR, FAULT, STALL
    );

endinterface

`default_nettype wire

// File: rtl/hall_debounce.sv
// ============================================================================
//  Module      : hall_debounce
//  Description : Two-flop synchroniser plus consecutive-sample debounce for
//                the hall code; emits the accepted code and a change pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hall_debounce #(
    parameter int W       = 3,
    parameter int DEB_CYC = 4
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    input  wire logic [W-1:0] i_raw,
    output logic      [W-1:0] o_code,
    output logic              o_chg
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic [W-1:0]  r_s1;
    logic [W-1:0]  r_s2;
    logic [W-1:0]  r_cand;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_chg;
    logic [CW-1:0] w_run;

    // Length of the current run of identical synchronised samples, this one included.
    assign w_run = (r_s2 == r_cand) ? (r_cnt + CW'(1)) : CW'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_cand <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_chg  <= 1'b0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_cand <= r_s2;
            r_chg  <= 1'b0;
            if (r_s2 == r_acc) begin
                r_cnt <= '0;
            end else if (w_run >= CW'(DEB_CYC)) begin
                r_acc <= r_s2;
                r_cnt <= '0;
                r_chg <= 1'b1;
            end else begin
                r_cnt <= w_run;
            end
        end
    end

    assign o_code = r_acc;
    assign o_chg  = r_chg;

endmodule

`default_nettype wire

// File: rtl/bldc_commutation_sequencer.sv
// ============================================================================
//  Module      : bldc_commutation_sequencer
//  Description : Six-step BLDC commutation with PWM high side, dead-time
//                insertion and invalid-hall / stall shutdown.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bldc_commutation_sequencer
    import bldc_pkg::*;
#(
    parameter int DEB_CYC   = 4,
    parameter int DEAD_CYC  = 8,
    parameter int STALL_CYC = 4096
) (
    input  wire logic                    CLK,
    input  wire logic                    RST_N,
    bldc_commutation_sequencer_if.slave  bus
);

    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam int SW = $clog2(STALL_CYC + 1);

    state_t           r_state;
    logic [DW-1:0]    r_dcnt;
    logic [SW-1:0]    r_stc;
    logic [PWM_W-1:0] r_pwm;
    logic [2:0]       r_pat;
    logic [5:0]       r_gate;
    logic [2:0]       r_sector;
    logic             r_fault;
    logic             r_stall;

    logic [2:0]       w_acc;
    logic             w_chg;
    hall_dec_t        w_dec;
    logic [2:0]       w_eff;
    logic             w_pwm_on;
    logic             w_stall_hit;

    hall_debounce #(
        .W       (3),
        .DEB_CYC (DEB_CYC)
    ) u_hall_debounce (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_raw  ({bus.H3, bus.H2, bus.H1}),
        .o_code (w_acc),
        .o_chg  (w_chg)
    );

    assign w_dec       = hall_decode(w_acc);
    assign w_eff       = eff_sector(w_dec.sector, bus.DIR);
    assign w_pwm_on    = (r_pwm < bus.DUTY);
    // True on the STALL_CYC-th consecutive RUN clock without a hall change.
    assign w_stall_hit = (r_stc >= SW'(STALL_CYC - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stc <= '0;
        end else if ((r_state != ST_RUN) || w_chg) begin
            r_stc <= '0;
        end else if (r_stc != SW'(STALL_CYC)) begin
            r_stc <= r_stc + SW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + PWM_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sector <= 3'd0;
        end else if (w_dec.valid) begin
            r_sector <= w_dec.sector;
        end
    end

    // Gates are assigned alongside the next state so a pattern change is
    // always preceded by exactly DEAD_CYC all-off clocks.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
            r_pat   <= 3'd0;
            r_gate  <= 6'b000_000;
            r_fault <= 1'b0;
            r_stall <= 1'b0;
        end else if (!bus.EN) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
            r_gate  <= 6'b000_000;
            r_fault <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_gate <= 6'b000_000;
                    if (w_dec.valid) begin
                        r_state <= ST_DEAD;
                        r_dcnt  <= '0;
                    end
                end
                ST_DEAD: begin
                    r_gate <= 6'b000_000;
                    if (!w_dec.valid) begin
                        r_state <= ST_FLT;
                        r_fault <= 1'b1;
                    end else if (r_dcnt == DW'(DEAD_CYC - 1)) begin
                        r_state <= ST_RUN;
                        r_pat   <= w_eff;
                        r_gate  <= gate_drive(w_eff, w_pwm_on);
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_dec.valid) begin
                        r_state <= ST_FLT;
                        r_fault <= 1'b1;
                        r_gate  <= 6'b000_000;
                    end else if (w_stall_hit) begin
                        r_state <= ST_FLT;
                        r_stall <= 1'b1;
                        r_gate  <= 6'b000_000;
                    end else if (w_eff != r_pat) begin
                        r_state <= ST_DEAD;
                        r_dcnt  <= '0;
                        r_gate  <= 6'b000_000;
                    end else begin
                        r_gate <= gate_drive(r_pat, w_pwm_on);
                    end
                end
                ST_FLT: begin
                    r_gate <= 6'b000_000;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gate  <= 6'b000_000;
                end
            endcase
        end
    end

    assign bus.A      = r_gate[5];
    assign bus.B      = r_gate[4];
    assign bus.C      = r_gate[3];
    assign bus.AA     = r_gate[2];
    assign bus.BB     = r_gate[1];
    assign bus.CC     = r_gate[0];
    assign bus.SECTOR = r_sector;
    assign bus.FAULT  = r_fault;
    assign bus.STALL  = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_bldc_commutation_sequencer.sv
// ============================================================================
//  Module      : tb_bldc_commutation_sequencer
//  Description : Self-checking bench: behavioural model compared every cycle
//                plus directed scenarios with literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bldc_commutation_sequencer;

    localparam int DEB   = 4;
    localparam int DEAD  = 8;
    localparam int STALLC = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bldc_commutation_sequencer_if bus ();

    bldc_commutation_sequencer #(
        .DEB_CYC   (DEB),
        .DEAD_CYC  (DEAD),
        .STALL_CYC (STALLC)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_GAP, M_DRIVE, M_TRIP} mmode_t;

    mmode_t     mm;
    int         gap_left;
    int         run_len;
    int         pat;
    int         m_pwm;
    logic [2:0] m_acc;
    logic [2:0] q[$];
    logic [5:0] m_gates;
    logic [2:0] m_sector;
    logic       m_fault;
    logic       m_stall;

    function automatic int hall_sec(input logic [2:0] c);
        case (c)
            3'b101:  return 0;
            3'b100:  return 1;
            3'b110:  return 2;
            3'b010:  return 3;
            3'b011:  return 4;
            3'b001:  return 5;
            default: return -1;
        endcase
    endfunction

    // Phase indices: A=0, B=1, C=2.
    function automatic logic [5:0] drive(input int s, input bit hi_on);
        int hi_ph[6];
        int lo_ph[6];
        logic [5:0] g;
        hi_ph = '{0, 0, 1, 1, 2, 2};
        lo_ph = '{1, 2, 2, 0, 0, 1};
        g = '0;
        if (hi_on) g[5 - hi_ph[s]] = 1'b1;
        g[2 - lo_ph[s]] = 1'b1;
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_step
        int  s;
        int  e;
        bit  ok;
        bit  hi_on;
        bit  same;
        if (!rst_n) begin
            mm = M_IDLE; gap_left = 0; run_len = 0; pat = 0; m_pwm = 0;
            m_acc = '0; m_gates = '0; m_sector = '0; m_fault = 0; m_stall = 0;
            q = {};
            for (int i = 0; i < DEB + 2; i++) q.push_back(3'b000);
        end else begin
            s     = hall_sec(m_acc);
            ok    = (s >= 0);
            e     = ok ? (bus.DIR ? (s + 3) % 6 : s) : 0;
            hi_on = (m_pwm < int'(bus.DUTY));
            if (ok) m_sector = s[2:0];
            if (!bus.EN) begin
                mm = M_IDLE; m_gates = '0; m_fault = 0; m_stall = 0;
            end else begin
                case (mm)
                    M_IDLE: begin
                        m_gates = '0;
                        if (ok) begin mm = M_GAP; gap_left = DEAD; end
                    end
                    M_GAP: begin
                        m_gates = '0;
                        if (!ok) begin mm = M_TRIP; m_fault = 1; end
                        else if (gap_left == 1) begin
                            mm = M_DRIVE; pat = e; run_len = 0; m_gates = drive(e, hi_on);
                        end else gap_left--;
                    end
                    M_DRIVE: begin
                        run_len++;
                        if (!ok) begin mm = M_TRIP; m_fault = 1; m_gates = '0; end
                        else if (run_len >= STALLC) begin mm = M_TRIP; m_stall = 1; m_gates = '0; end
                        else if (e != pat) begin mm = M_GAP; gap_left = DEAD; m_gates = '0; end
                        else m_gates = drive(pat, hi_on);
                    end
                    default: m_gates = '0;
                endcase
            end
            m_pwm = (m_pwm + 1) % 16;
            // q[0] = raw at this edge; q[2..DEB+1] = the synchronised samples seen by the debouncer.
            q.push_front({bus.H3, bus.H2, bus.H1});
            while (q.size() > DEB + 2) void'(q.pop_back());
            same = 1;
            for (int i = 3; i < DEB + 2; i++) if (q[i] != q[2]) same = 0;
            if (same && (q[2] != m_acc)) m_acc = q[2];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [5:0] dg;
        dg = {bus.A, bus.B, bus.C, bus.AA, bus.BB, bus.CC};
        chk("overlap", int'((dg[5] & dg[2]) | (dg[4] & dg[1]) | (dg[3] & dg[0])), 0);
        if (!rst_n) begin
            chk("rst_gates", int'(dg), 0);
            chk("rst_sector", int'(bus.SECTOR), 0);
            chk("rst_flags", int'({bus.FAULT, bus.STALL}), 0);
        end else begin
            chk("gates", int'(dg), int'(m_gates));
            chk("sector", int'(bus.SECTOR), int'(m_sector));
            chk("fault", int'(bus.FAULT), int'(m_fault));
            chk("stall", int'(bus.STALL), int'(m_stall));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_hall(input logic [2:0] h);
        {bus.H3, bus.H2, bus.H1} = h;
    endtask

    function automatic logic [5:0] gates_now();
        return {bus.A, bus.B, bus.C, bus.AA, bus.BB, bus.CC};
    endfunction

    // Counts all-off clocks over n cycles.
    task automatic hold_count_off(input int n, output int off);
        off = 0;
        repeat (n) begin
            tick(1);
            if (gates_now() == 6'b0) off++;
        end
    endtask

    initial begin : stim
        int cnt;
        int off;
        int a_cnt;
        int bb_cnt;
        int oth;
        logic [2:0] codes[5];
        logic [2:0] lo_exp[5];
        codes  = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        lo_exp = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b010};

        bus.EN = 0; bus.DIR = 0; bus.DUTY = 0; set_hall(3'b000);
        // Reset with random inputs
        repeat (5) begin
            tick(1);
            bus.EN = 1'($urandom); bus.DIR = 1'($urandom);
            bus.DUTY = 4'($urandom); set_hall(3'($urandom));
        end
        chk("reset_gates", int'(gates_now()), 0);
        chk("reset_sector", int'(bus.SECTOR), 0);
        chk("reset_fault", int'(bus.FAULT), 0);
        chk("reset_stall", int'(bus.STALL), 0);
        bus.EN = 0; bus.DIR = 0; bus.DUTY = 4'd15; set_hall(3'b000);
        rst_n = 1'b1;
        tick(20);
        chk("idle_after_reset", int'(gates_now()), 0);

        // Startup: 2 sync + 4 debounce + 1 FSM + 8 dead -> first drive after 15 clocks
        set_hall(3'b101); bus.EN = 1;
        cnt = 0;
        while (bus.BB !== 1'b1 && cnt < 100) begin tick(1); cnt++; end
        chk("startup_latency", cnt, 15);
        a_cnt = 0; bb_cnt = 0; oth = 0;
        repeat (16) begin
            tick(1);
            a_cnt += int'(bus.A); bb_cnt += int'(bus.BB);
            oth += int'(bus.B) + int'(bus.C) + int'(bus.AA) + int'(bus.CC);
        end
        chk("duty15_A_high", a_cnt, 15);
        chk("duty15_BB_high", bb_cnt, 16);
        chk("duty15_others", oth, 0);

        // Forward rotation
        for (int k = 0; k < 5; k++) begin
            set_hall(codes[k]);
            hold_count_off(1000, off);
            chk("rot_dead_gap", off, DEAD);
            chk("rot_sector", int'(bus.SECTOR), k + 1);
            chk("rot_low_side", int'(gates_now() & 6'b000111), int'(lo_exp[k]));
        end

        // Reverse mid-run: sector 5 -> effective 2 (B / CC)
        bus.DIR = 1;
        hold_count_off(200, off);
        chk("dir_dead_gap", off, DEAD);
        chk("dir_low_side", int'(gates_now() & 6'b000111), 1);
        chk("dir_sector", int'(bus.SECTOR), 5);

        // Glitch shorter than the debounce window
        set_hall(3'b000); tick(3); set_hall(3'b001);
        hold_count_off(100, off);
        chk("glitch_no_gap", off, 0);
        chk("glitch_sector", int'(bus.SECTOR), 5);
        chk("glitch_no_fault", int'(bus.FAULT), 0);

        // Invalid hall code
        set_hall(3'b111);
        tick(7);
        chk("inv_fault", int'(bus.FAULT), 1);
        chk("inv_gates", int'(gates_now()), 0);
        tick(3); set_hall(3'b001); tick(20);
        chk("inv_fault_sticky", int'(bus.FAULT), 1);
        bus.EN = 0; tick(1);
        chk("inv_fault_cleared", int'(bus.FAULT), 0);
        bus.EN = 1; tick(30);

        // Stall: DIR change starts the gap at once; RUN begins 9 clocks in, trips 4096 later
        bus.DIR = 0; set_hall(3'b100);
        cnt = 0;
        while (bus.STALL !== 1'b1 && cnt < 6000) begin tick(1); cnt++; end
        chk("stall_time", cnt, 9 + STALLC);
        chk("stall_gates", int'(gates_now()), 0);
        chk("stall_no_fault", int'(bus.FAULT), 0);

        // DUTY=0 boundary: sector 1 -> A / CC, high side never on
        bus.EN = 0; tick(1);
        chk("stall_cleared", int'(bus.STALL), 0);
        bus.EN = 1; bus.DUTY = 4'd0; tick(20);
        a_cnt = 0; bb_cnt = 0;
        repeat (32) begin
            tick(1);
            a_cnt += int'(bus.A) + int'(bus.B) + int'(bus.C);
            bb_cnt += int'(bus.CC);
        end
        chk("duty0_high_side", a_cnt, 0);
        chk("duty0_CC_high", bb_cnt, 32);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
